freq_sweep_gen: RTL and testbench
=================================

// Module: freq_sweep_gen
// PURPOSE
//  Upstream stage of the DDS phase accumulator. Generates a 64-bit frequency control word
//  that steps from f_start to f_stop in f_step increments, holding each value for dwell+1
//  clocks. Supports single-shot, triangle and sawtooth sweeps. Output freq_c drives the
//  accumulator fre_c input directly, in place of a fixed freq_ctrl word.
// PARAMETERS
//  FW       64   frequency word width (must equal accumulator fre_c width)
//  DWELL_W  24   dwell counter width
// PORTS
//  clk      in   1       system clock
//  rst      in   1       asynchronous, active-low reset
//  start    in   1       1-cycle request, sampled only in IDLE
//  abort    in   1       stop the sweep, level-sampled
//  hold     in   1       freeze the dwell counter while high
//  mode     in   2       0 single up, 1 single down, 2 triangle, 3 sawtooth up; latched at start
//  f_start  in   FW      lower bound; latched at start
//  f_stop   in   FW      upper bound; latched at start
//  f_step   in   FW      increment; latched at start
//  dwell    in   DWELL_W clocks per step minus 1; latched at start
//  freq_c   out  FW      current frequency word; registered
//  freq_vld out  1       1-cycle pulse on every freq_c update, including repeats
//  busy     out  1       high in RUN
//  done     out  1       1-cycle pulse at the end of a single-shot sweep
//  err      out  1       1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset: state=IDLE; freq_c=0; freq_vld=busy=done=err=0; dwell count=0; dir=up.
//  FSM states are IDLE and RUN. All outputs are registered.
//  IDLE + start + !abort:
//   - If f_start>f_stop or f_step==0: err=1 next cycle, stay in IDLE, freq_c unchanged.
//   - Else: latch the config and go to RUN. Next cycle freq_c = f_stop for mode 1,
//     f_start for all other modes; freq_vld=1; busy=1; count=dwell; dir=down for mode 1,
//     up otherwise.
//  IDLE + start + abort: abort wins; start is ignored; err stays 0.
//  RUN, count!=0: count decrements each clock unless hold=1 (then frozen).
//   freq_c is stable; freq_vld=0.
//  RUN, count==0, hold=0: update edge. count reloads to dwell, so successive updates are
//   exactly dwell+1 clocks apart (dwell=0 means an update every clock).
//   - Up, freq_c!=f_stop: next = min(freq_c+f_step, f_stop). Compute the sum in FW+1 bits;
//     a carry-out also clamps to f_stop.
//   - Down, freq_c!=f_start: next = max(freq_c-f_step, f_start). A borrow clamps to f_start.
//   - At the endpoint (up and freq_c==f_stop, or down and freq_c==f_start):
//     - mode 0/1: go to IDLE; done=1, busy=0 on the same edge; freq_c holds, no freq_vld.
//     - mode 2: reverse dir and apply the step in the new direction on this edge.
//     - mode 3: reload freq_c=f_start; dir stays up.
//   - freq_vld=1 on every update edge except the terminal edge of mode 0/1.
//  RUN, count==0, hold=1: no update; the state waits.
//  abort in RUN: go to IDLE next edge; busy=0; freq_c keeps its last value; no done,
//   no freq_vld. abort overrides a coincident update edge.
//  start in RUN is ignored. Input changes after start have no effect until the next start.
//  f_start==f_stop: the first update reaches the endpoint. Modes 0/1 finish after dwell+1
//   clocks. Mode 2 flips direction each update and mode 3 reloads, both emitting a constant
//   freq_c with freq_vld.
//  Reset mid-sweep: all outputs return to reset values asynchronously.
// STRUCTURE
//  Shared package dds_pkg holds FW, the MODE_SINGLE_UP/SINGLE_DN/TRI/SAW constants
//  and the IDLE/RUN state encoding.
//  One sub-module, freq_step_clamp: combinational. Inputs are cur, step, lo, hi and dir.
//  Outputs are next (clamped) and at_end. It is instantiated once.
// TESTING
//  1. mode0, start=100, stop=130, step=10, dwell=2 -> freq_c 100,110,120,130 with freq_vld
//     every 3 clks; done 3 clks after 130; busy falls with done.
//  2. mode2, start=0, stop=25, step=10, dwell=0 -> 0,10,20,25,15,5,0,10,... every clock;
//     busy stays high; done never asserts.
//  3. Clamp/overflow: mode0, start=2^64-20, stop=2^64-1, step=2^63 -> second value is
//     2^64-1; no wrap to a small value.
//  4. Reject: start=50, stop=40 -> err pulse, busy=0, freq_c unchanged.
//     step=0 -> err pulse, busy=0, freq_c unchanged.
//  5. Abort and simultaneity:
//     - abort mid-dwell -> IDLE next edge, freq_c held, no done.
//     - abort on an update edge -> no freq_vld.
//     - start+abort in IDLE -> nothing happens.
//  6. hold=1 for 5 clks in mode3 -> update delayed exactly 5 clks. Then rst low mid-run
//     -> freq_c=0, busy=0 immediately.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS front end: word width, sweep modes,
// sweep direction encoding and the sweep generator state encoding.
package dds_pkg;

    // Frequency word width; must match the phase accumulator fre_c width.
    localparam int unsigned FW = 64;

    // Sweep modes, latched at start.
    localparam logic [1:0] MODE_SINGLE_UP = 2'd0;
    localparam logic [1:0] MODE_SINGLE_DN = 2'd1;
    localparam logic [1:0] MODE_TRI       = 2'd2;
    localparam logic [1:0] MODE_SAW       = 2'd3;

    // Sweep direction.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Sweep generator states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_t;

endpackage : dds_pkg

// File: rtl/freq_step_clamp.sv
// One sweep step with saturation at the sweep bounds.
// When the current word already sits on the endpoint of the requested
// direction, the step is taken the other way; that is exactly the triangle
// turnaround, and the other modes simply ignore o_next on an endpoint.
module freq_step_clamp
    import dds_pkg::*;
#(
    parameter int unsigned W = FW
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_step,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_hi,
    input  logic         i_dir,
    output logic [W-1:0] o_next,
    output logic         o_at_end
);

    logic         w_dir_eff;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;

    // Endpoint detection and clamped next word; the extra MSB catches carry/borrow.
    always_comb begin
        o_at_end  = (i_dir == DIR_DN) ? (i_cur == i_lo) : (i_cur == i_hi);
        w_dir_eff = o_at_end ? ~i_dir : i_dir;
        w_sum     = {1'b0, i_cur} + {1'b0, i_step};
        w_diff    = {1'b0, i_cur} - {1'b0, i_step};
        if (w_dir_eff == DIR_UP) begin
            if (w_sum[W] || (w_sum[W-1:0] > i_hi)) begin
                o_next = i_hi;
            end else begin
                o_next = w_sum[W-1:0];
            end
        end else begin
            if (w_diff[W] || (w_diff[W-1:0] < i_lo)) begin
                o_next = i_lo;
            end else begin
                o_next = w_diff[W-1:0];
            end
        end
    end

endmodule : freq_step_clamp

// File: rtl/freq_sweep_gen.sv
// Frequency sweep generator feeding the DDS phase accumulator fre_c input.
// Steps a frequency word between two bounds with a programmable dwell per
// step; single-shot up/down, triangle and sawtooth sweeps.
module freq_sweep_gen
    import dds_pkg::*;
#(
    parameter int unsigned FW_P    = FW,
    parameter int unsigned DWELL_W = 24
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_hold,
    input  logic [1:0]          i_mode,
    input  logic [FW_P-1:0]     i_f_start,
    input  logic [FW_P-1:0]     i_f_stop,
    input  logic [FW_P-1:0]     i_f_step,
    input  logic [DWELL_W-1:0]  i_dwell,
    output logic [FW_P-1:0]     o_freq_c,
    output logic                o_freq_vld,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    sweep_state_t          r_state;
    logic [FW_P-1:0]       r_freq_c;
    logic                  r_freq_vld;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [DWELL_W-1:0]    r_cnt;
    logic                  r_dir;
    logic [1:0]            r_mode;
    logic [FW_P-1:0]       r_lo;
    logic [FW_P-1:0]       r_hi;
    logic [FW_P-1:0]       r_step;
    logic [DWELL_W-1:0]    r_dwell;

    logic [FW_P-1:0]       w_next;
    logic                  w_at_end;

    freq_step_clamp #(
        .W (FW_P)
    ) u_step (
        .i_cur    (r_freq_c),
        .i_step   (r_step),
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .i_dir    (r_dir),
        .o_next   (w_next),
        .o_at_end (w_at_end)
    );

    // Sweep FSM: config latch, dwell timing, word update and status pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_freq_c   <= {FW_P{1'b0}};
            r_freq_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= {DWELL_W{1'b0}};
            r_dir      <= DIR_UP;
            r_mode     <= MODE_SINGLE_UP;
            r_lo       <= {FW_P{1'b0}};
            r_hi       <= {FW_P{1'b0}};
            r_step     <= {FW_P{1'b0}};
            r_dwell    <= {DWELL_W{1'b0}};
        end else begin
            // Pulses default low; set only on the edge that produces them.
            r_freq_vld <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    // abort beats a coincident start
                    if (i_start && !i_abort) begin
                        if ((i_f_start > i_f_stop) || (i_f_step == {FW_P{1'b0}})) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= RUN;
                            r_mode     <= i_mode;
                            r_lo       <= i_f_start;
                            r_hi       <= i_f_stop;
                            r_step     <= i_f_step;
                            r_dwell    <= i_dwell;
                            r_cnt      <= i_dwell;
                            r_freq_vld <= 1'b1;
                            r_busy     <= 1'b1;
                            if (i_mode == MODE_SINGLE_DN) begin
                                r_freq_c <= i_f_stop;
                                r_dir    <= DIR_DN;
                            end else begin
                                r_freq_c <= i_f_start;
                                r_dir    <= DIR_UP;
                            end
                        end
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != {DWELL_W{1'b0}}) begin
                        if (!i_hold) begin
                            r_cnt <= r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
                        end
                    end else if (!i_hold) begin
                        // Update edge: the reload keeps updates dwell+1 clocks apart.
                        r_cnt <= r_dwell;
                        if (w_at_end) begin
                            case (r_mode)
                                MODE_TRI: begin
                                    r_freq_c   <= w_next;
                                    r_dir      <= ~r_dir;
                                    r_freq_vld <= 1'b1;
                                end
                                MODE_SAW: begin
                                    r_freq_c   <= r_lo;
                                    r_freq_vld <= 1'b1;
                                end
                                default: begin
                                    // single-shot sweep finished; word holds
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_freq_c   <= w_next;
                            r_freq_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_freq_c   = r_freq_c;
    assign o_freq_vld = r_freq_vld;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule : freq_sweep_gen

// File: tb/tb_freq_sweep_gen.sv
// Directed test of freq_sweep_gen with hand-computed expected sequences.
module tb_freq_sweep_gen;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         hold;
    logic [1:0]   mode;
    logic [63:0]  f_start;
    logic [63:0]  f_stop;
    logic [63:0]  f_step;
    logic [23:0]  dwell;
    logic [63:0]  freq_c;
    logic         freq_vld;
    logic         busy;
    logic         done;
    logic         err;

    int n_total;
    int n_bad;

    freq_sweep_gen #(
        .FW_P    (64),
        .DWELL_W (24)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_hold     (hold),
        .i_mode     (mode),
        .i_f_start  (f_start),
        .i_f_stop   (f_stop),
        .i_f_step   (f_step),
        .i_dwell    (dwell),
        .o_freq_c   (freq_c),
        .o_freq_vld (freq_vld),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // advance one clock, sample 1 ns after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [63:0] fs, input logic [63:0] fe,
                            input logic [63:0] st, input logic [23:0] dw);
        mode    = m;
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    logic [63:0] tri_exp [0:8];

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        hold    = 1'b0;
        mode    = 2'd0;
        f_start = 64'd0;
        f_stop  = 64'd0;
        f_step  = 64'd0;
        dwell   = 24'd0;
        tri_exp[0] = 64'd0;  tri_exp[1] = 64'd10; tri_exp[2] = 64'd20;
        tri_exp[3] = 64'd25; tri_exp[4] = 64'd15; tri_exp[5] = 64'd5;
        tri_exp[6] = 64'd0;  tri_exp[7] = 64'd10; tri_exp[8] = 64'd20;

        // reset values
        #3;
        check_val("rst_freq", freq_c, 64'd0);
        check_val("rst_vld", {63'd0, freq_vld}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_err", {63'd0, err}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single up 100..130 step 10 dwell 2
        do_start(2'd0, 64'd100, 64'd130, 64'd10, 24'd2);
        check_val("t1_first", freq_c, 64'd100);
        check_val("t1_first_vld", {63'd0, freq_vld}, 64'd1);
        check_val("t1_busy", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val("t1_dwell_vld", {63'd0, freq_vld}, 64'd0);
            tick();
            check_val("t1_dwell_freq", freq_c, 64'd100 + 64'(10 * (k - 1)));
            tick();
            check_val("t1_step", freq_c, 64'd100 + 64'(10 * k));
            check_val("t1_step_vld", {63'd0, freq_vld}, 64'd1);
        end
        tick();
        tick();
        check_val("t1_pre_done", {63'd0, done}, 64'd0);
        check_val("t1_pre_busy", {63'd0, busy}, 64'd1);
        tick();
        check_val("t1_done", {63'd0, done}, 64'd1);
        check_val("t1_busy_low", {63'd0, busy}, 64'd0);
        check_val("t1_end_vld", {63'd0, freq_vld}, 64'd0);
        check_val("t1_end_freq", freq_c, 64'd130);
        tick();
        check_val("t1_done_pulse", {63'd0, done}, 64'd0);

        // 2: triangle 0..25 step 10 dwell 0, then abort on an update edge
        do_start(2'd2, 64'd0, 64'd25, 64'd10, 24'd0);
        check_val("t2_first", freq_c, tri_exp[0]);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val("t2_seq", freq_c, tri_exp[i]);
            check_val("t2_vld", {63'd0, freq_vld}, 64'd1);
            check_val("t2_busy", {63'd0, busy}, 64'd1);
            check_val("t2_nodone", {63'd0, done}, 64'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t5_abort_upd_vld", {63'd0, freq_vld}, 64'd0);
        check_val("t5_abort_upd_busy", {63'd0, busy}, 64'd0);
        check_val("t5_abort_upd_freq", freq_c, 64'd20);

        // 3: carry-out clamps to stop instead of wrapping
        do_start(2'd0, 64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 24'd0);
        check_val("t3_first", freq_c, 64'hFFFF_FFFF_FFFF_FFEC);
        tick();
        check_val("t3_clamp", freq_c, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("t3_clamp_vld", {63'd0, freq_vld}, 64'd1);
        tick();
        check_val("t3_done", {63'd0, done}, 64'd1);
        check_val("t3_freq_hold", freq_c, 64'hFFFF_FFFF_FFFF_FFFF);

        // 4: rejected starts
        do_start(2'd0, 64'd50, 64'd40, 64'd1, 24'd0);
        check_val("t4_err_order", {63'd0, err}, 64'd1);
        check_val("t4_busy_order", {63'd0, busy}, 64'd0);
        check_val("t4_freq_order", freq_c, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("t4_vld_order", {63'd0, freq_vld}, 64'd0);
        tick();
        check_val("t4_err_pulse", {63'd0, err}, 64'd0);
        do_start(2'd0, 64'd10, 64'd40, 64'd0, 24'd0);
        check_val("t4_err_step0", {63'd0, err}, 64'd1);
        check_val("t4_busy_step0", {63'd0, busy}, 64'd0);
        check_val("t4_freq_step0", freq_c, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // 5: abort mid-dwell
        do_start(2'd0, 64'd100, 64'd130, 64'd10, 24'd4);
        check_val("t5_first", freq_c, 64'd100);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t5_abort_busy", {63'd0, busy}, 64'd0);
        check_val("t5_abort_freq", freq_c, 64'd100);
        check_val("t5_abort_done", {63'd0, done}, 64'd0);
        tick();
        check_val("t5_abort_done2", {63'd0, done}, 64'd0);

        // 5: start together with abort in IDLE does nothing
        mode    = 2'd0;
        f_start = 64'd200;
        f_stop  = 64'd300;
        f_step  = 64'd1;
        dwell   = 24'd0;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        check_val("t5_sa_busy", {63'd0, busy}, 64'd0);
        check_val("t5_sa_vld", {63'd0, freq_vld}, 64'd0);
        check_val("t5_sa_err", {63'd0, err}, 64'd0);
        check_val("t5_sa_freq", freq_c, 64'd100);

        // 6: sawtooth 0..20 step 10 dwell 1, hold for 5 clocks after the first word
        do_start(2'd3, 64'd0, 64'd20, 64'd10, 24'd1);
        check_val("t6_first", freq_c, 64'd0);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t6_hold_vld", {63'd0, freq_vld}, 64'd0);
        end
        hold = 1'b0;
        tick();
        check_val("t6_late_vld", {63'd0, freq_vld}, 64'd0);
        check_val("t6_late_freq", freq_c, 64'd0);
        tick();
        check_val("t6_step1", freq_c, 64'd10);
        check_val("t6_step1_vld", {63'd0, freq_vld}, 64'd1);
        tick();
        tick();
        check_val("t6_step2", freq_c, 64'd20);
        tick();
        tick();
        check_val("t6_reload", freq_c, 64'd0);
        check_val("t6_reload_vld", {63'd0, freq_vld}, 64'd1);
        tick();
        tick();
        check_val("t6_after_reload", freq_c, 64'd10);
        check_val("t6_busy", {63'd0, busy}, 64'd1);

        // 6: asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_freq", freq_c, 64'd0);
        check_val("t6_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("t6_rst_idle", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_freq_sweep_gen
